// File: rtl/ip_pkt_pkg.sv
// ip_pkt_pkg: shared constants, FSM state type and header byte offsets
// for the IPv4 (IHL=5) + TCP (no options) receive parser.
package ip_pkt_pkg;

    localparam logic [7:0]  IP_VER_IHL = 8'h45;
    localparam logic [7:0]  PROTO_TCP  = 8'd6;
    localparam int unsigned HDR_BYTES  = 40;

    // Packet byte offsets of the header fields (big-endian multi-byte fields)
    localparam int unsigned OFF_VER_IHL  = 0;
    localparam int unsigned OFF_TOT_LEN  = 2;
    localparam int unsigned OFF_PROTO    = 9;
    localparam int unsigned OFF_SRC_IP   = 12;
    localparam int unsigned OFF_DST_IP   = 16;
    localparam int unsigned OFF_SRC_PORT = 20;
    localparam int unsigned OFF_DST_PORT = 22;
    localparam int unsigned OFF_SEQ      = 24;
    localparam int unsigned OFF_ACK      = 28;
    localparam int unsigned OFF_FLAGS    = 33;

    typedef enum logic [1:0] {
        HDR,
        PAYLOAD,
        DROP
    } state_t;

    // Byte lane within a 64-bit beat for a packet byte offset
    function automatic logic [2:0] lane(input int unsigned off);
        return 3'(off % 8);
    endfunction

    function automatic logic [7:0] get_byte(input logic [63:0] d, input logic [2:0] l);
        return d[{l, 3'b000} +: 8];
    endfunction

    function automatic logic [15:0] be16(input logic [63:0] d, input logic [2:0] l);
        return {get_byte(d, l), get_byte(d, l + 3'd1)};
    endfunction

    function automatic logic [31:0] be32(input logic [63:0] d, input logic [2:0] l);
        return {be16(d, l), be16(d, l + 3'd2)};
    endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// ip_csum_acc: ones'-complement accumulator of up to four big-endian
// halfwords per beat, with a 17-bit end-around-carry register.
// Only built when IP_CSUM_CHECK_EN is defined.
`ifdef IP_CSUM_CHECK_EN
module ip_csum_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add,
    input  logic [63:0] data,
    input  logic [3:0]  hw_en,
    output logic [15:0] sum
);

    logic [16:0] acc;
    logic [16:0] acc_next;
    logic [16:0] fold;

    function automatic logic [16:0] oc_add(input logic [16:0] a, input logic [15:0] h);
        return {1'b0, a[15:0]} + {16'h0, a[16]} + {1'b0, h};
    endfunction

    // Fold the enabled halfwords of this beat into the running sum
    always_comb begin
        acc_next = clr ? '0 : acc;
        if (add && hw_en[0]) acc_next = oc_add(acc_next, {data[7:0],   data[15:8]});
        if (add && hw_en[1]) acc_next = oc_add(acc_next, {data[23:16], data[31:24]});
        if (add && hw_en[2]) acc_next = oc_add(acc_next, {data[39:32], data[47:40]});
        if (add && hw_en[3]) acc_next = oc_add(acc_next, {data[55:48], data[63:56]});
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else        acc <= acc_next;
    end

    assign fold = {1'b0, acc[15:0]} + {16'h0, acc[16]};
    assign sum  = fold[15:0] + {15'h0, fold[16]};

endmodule
`endif

// File: rtl/ip_packet_parser.sv
// ip_packet_parser: parses/filters the 40-byte IPv4+TCP header of a 64-bit
// AXI-Stream, emits a one-cycle header record and forwards the payload.
// Define IP_CSUM_CHECK_EN to also verify the IP header checksum.
module ip_packet_parser
    import ip_pkt_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned HDR_BEATS = 5
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [31:0]      local_ip_addr,
    input  logic [15:0]      local_port,
    input  logic [63:0]      s_tdata,
    input  logic [7:0]       s_tkeep,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic [63:0]      m_tdata,
    output logic [7:0]       m_tkeep,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic             hdr_valid,
    output logic [31:0]      hdr_src_ip,
    output logic [15:0]      hdr_src_port,
    output logic [31:0]      hdr_seq,
    output logic [31:0]      hdr_ack,
    output logic [7:0]       hdr_tcp_flags,
    output logic [15:0]      hdr_payload_len,
    output logic [CNT_W-1:0] pkt_ok_cnt,
    output logic [CNT_W-1:0] pkt_drop_cnt
);

    localparam logic [2:0]  LAST_HDR_BEAT = 3'(HDR_BEATS - 1);
    localparam logic [15:0] MIN_TOT_LEN   = 16'(HDR_BYTES);

    state_t      state, state_next;
    logic [2:0]  beat_cnt;
    logic        err_q;
    logic        beat_acc, hdr_beat, last_hdr;
    logic        beat_err, pkt_err, csum_bad;
    logic        ok_inc, drop_inc;
    logic [15:0] tot_len;
    logic [15:0] plen_q, src_port_q;
    logic [31:0] src_ip_q, seq_q, ack_q;

    assign beat_acc = s_tvalid & s_tready;
    assign hdr_beat = (state == HDR) & beat_acc;
    assign last_hdr = (beat_cnt == LAST_HDR_BEAT);
    assign tot_len  = be16(s_tdata, lane(OFF_TOT_LEN));

    // Header checks that apply to the beat currently on the input
    always_comb begin
        beat_err = (s_tkeep != '1);
        case (beat_cnt)
            3'd0: beat_err = beat_err
                           | (get_byte(s_tdata, lane(OFF_VER_IHL)) != IP_VER_IHL)
                           | (tot_len < MIN_TOT_LEN);
            3'd1: beat_err = beat_err | (get_byte(s_tdata, lane(OFF_PROTO)) != PROTO_TCP);
            3'd2: beat_err = beat_err
                           | (be32(s_tdata, lane(OFF_DST_IP)) != local_ip_addr)
                           | (be16(s_tdata, lane(OFF_DST_PORT)) != local_port);
            default: ;
        endcase
    end

`ifdef IP_CSUM_CHECK_EN
    logic [15:0] csum;

    // Halfwords 0-9 of the IP header: all of beats 0-1, first half of beat 2
    ip_csum_acc u_csum (
        .clk   (aclk),
        .rst_n (aresetn),
        .clr   (hdr_beat && (beat_cnt == 3'd0)),
        .add   (hdr_beat && (beat_cnt <= 3'd2)),
        .data  (s_tdata),
        .hw_en ((beat_cnt == 3'd2) ? 4'b0011 : 4'b1111),
        .sum   (csum)
    );

    assign csum_bad = last_hdr & (csum != 16'hFFFF);
`else
    assign csum_bad = 1'b0;
`endif

    // Sticky error is ignored on beat 0 so each packet starts clean
    assign pkt_err  = ((beat_cnt != 3'd0) & err_q) | beat_err | csum_bad;
    assign ok_inc   = hdr_beat & last_hdr & ~pkt_err;
    assign drop_inc = hdr_beat & ((s_tlast & ~last_hdr) | (last_hdr & pkt_err));

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= HDR;
        else          state <= state_next;
    end

    // Next state and stream handshake/pass-through outputs
    always_comb begin
        state_next = state;
        s_tready   = 1'b1;
        m_tdata    = '0;
        m_tkeep    = '0;
        m_tvalid   = 1'b0;
        m_tlast    = 1'b0;
        case (state)
            HDR: begin
                if (hdr_beat && last_hdr && !s_tlast)
                    state_next = pkt_err ? DROP : PAYLOAD;
            end
            PAYLOAD: begin
                s_tready = m_tready;
                m_tdata  = s_tdata;
                m_tkeep  = s_tkeep;
                m_tvalid = s_tvalid;
                m_tlast  = s_tlast;
                if (beat_acc && s_tlast) state_next = HDR;
            end
            DROP: begin
                if (beat_acc && s_tlast) state_next = HDR;
            end
            default: state_next = HDR;
        endcase
    end

    // Header beat counter, sticky error and per-beat field capture
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt   <= '0;
            err_q      <= 1'b0;
            plen_q     <= '0;
            src_ip_q   <= '0;
            src_port_q <= '0;
            seq_q      <= '0;
            ack_q      <= '0;
        end else if (hdr_beat) begin
            beat_cnt <= (s_tlast || last_hdr) ? '0 : beat_cnt + 3'd1;
            err_q    <= pkt_err;
            case (beat_cnt)
                3'd0: if (tot_len >= MIN_TOT_LEN) plen_q <= tot_len - MIN_TOT_LEN;
                3'd1: src_ip_q   <= be32(s_tdata, lane(OFF_SRC_IP));
                3'd2: src_port_q <= be16(s_tdata, lane(OFF_SRC_PORT));
                3'd3: begin
                    seq_q <= be32(s_tdata, lane(OFF_SEQ));
                    ack_q <= be32(s_tdata, lane(OFF_ACK));
                end
                default: ;
            endcase
        end
    end

    // Header record publication and saturating packet counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hdr_valid       <= 1'b0;
            hdr_src_ip      <= '0;
            hdr_src_port    <= '0;
            hdr_seq         <= '0;
            hdr_ack         <= '0;
            hdr_tcp_flags   <= '0;
            hdr_payload_len <= '0;
            pkt_ok_cnt      <= '0;
            pkt_drop_cnt    <= '0;
        end else begin
            hdr_valid <= ok_inc;
            if (ok_inc) begin
                hdr_src_ip      <= src_ip_q;
                hdr_src_port    <= src_port_q;
                hdr_seq         <= seq_q;
                hdr_ack         <= ack_q;
                hdr_tcp_flags   <= get_byte(s_tdata, lane(OFF_FLAGS));
                hdr_payload_len <= plen_q;
            end
            if (ok_inc && (pkt_ok_cnt != '1))     pkt_ok_cnt   <= pkt_ok_cnt + 1'b1;
            if (drop_inc && (pkt_drop_cnt != '1)) pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ip_packet_parser.sv
// tb_ip_packet_parser: directed, table-driven bench for ip_packet_parser.
module tb_ip_packet_parser;

    localparam logic [31:0] LOCAL_IP  = 32'hddccbbaa;
    localparam logic [15:0] LOCAL_PORT = 16'd1024;
    localparam logic [31:0] SRC_IP    = 32'hc0a8010a;
    localparam logic [15:0] SRC_PORT  = 16'h1388;
    localparam logic [31:0] SEQ_NUM   = 32'h11223344;
    localparam logic [31:0] ACK_NUM   = 32'h55667788;

    logic        aclk, aresetn;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tlast, s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tlast, m_tready;
    logic        hdr_valid;
    logic [31:0] hdr_src_ip, hdr_seq, hdr_ack;
    logic [15:0] hdr_src_port, hdr_payload_len;
    logic [7:0]  hdr_tcp_flags;
    logic [15:0] pkt_ok_cnt, pkt_drop_cnt;

    ip_packet_parser #(.CNT_W(16), .HDR_BEATS(5)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .local_ip_addr(LOCAL_IP), .local_port(LOCAL_PORT),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .hdr_valid(hdr_valid), .hdr_src_ip(hdr_src_ip), .hdr_src_port(hdr_src_port),
        .hdr_seq(hdr_seq), .hdr_ack(hdr_ack), .hdr_tcp_flags(hdr_tcp_flags),
        .hdr_payload_len(hdr_payload_len), .pkt_ok_cnt(pkt_ok_cnt), .pkt_drop_cnt(pkt_drop_cnt)
    );

    typedef struct {
        logic [31:0] dst_ip;
        logic [15:0] dst_port;
        logic [15:0] tot_len;
        logic [7:0]  flags;
        int          n_pay;
        int          runt_beats;
        int          corrupt_byte;
        int          bad_keep_beat;
        int          exp_hdr;
        int          exp_ok;
        int          exp_drop;
        int          exp_acc;
        int          exp_pay;
        logic [15:0] exp_plen;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    int checks = 0;
    int errors = 0;

    logic [63:0] tx_data_q[$];
    logic [7:0]  tx_keep_q[$];
    logic        tx_last_q[$];
    logic [63:0] exp_q[$];
    logic [72:0] mq[$];

    int          hdr_cnt, acc_cnt, stall_cnt;
    logic [31:0] cap_src_ip, cap_seq, cap_ack;
    logic [15:0] cap_src_port, cap_plen;
    logic [7:0]  cap_flags;
    logic        prev_stall;
    logic [63:0] prev_data;
    bit          toggle_mode;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            if (toggle_mode) m_tready = ~m_tready;
            else             m_tready = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sample away from the active edge: inputs settle at posedge+1
    always @(negedge aclk) begin
        if (s_tvalid && s_tready) acc_cnt++;
        if (m_tvalid && m_tready) mq.push_back({m_tlast, m_tkeep, m_tdata});
        if (hdr_valid) begin
            hdr_cnt++;
            cap_src_ip   = hdr_src_ip;
            cap_src_port = hdr_src_port;
            cap_seq      = hdr_seq;
            cap_ack      = hdr_ack;
            cap_flags    = hdr_tcp_flags;
            cap_plen     = hdr_payload_len;
        end
        if (m_tvalid) check("s_tready_mirrors_m_tready", s_tready, m_tready);
        if (prev_stall) begin
            check("stall_valid_held", m_tvalid, 1);
            check("stall_data_stable", m_tdata, prev_data);
        end
        prev_stall = m_tvalid && !m_tready;
        if (prev_stall) stall_cnt++;
        prev_data = m_tdata;
    end

    function automatic vec_t mkv(input logic [31:0] ip, input logic [15:0] port, input logic [15:0] len,
                                 input logic [7:0] flags, input int npay, input int exp_pay);
        vec_t v;
        v = '{ip, port, len, flags, npay, 0, -1, -1, 0, 0, 0, 0, exp_pay, 16'd0};
        return v;
    endfunction

    // Appends one packet's beats to the tx queues and its expected payload to exp_q
    function automatic void build_pkt(input vec_t v, input int id);
        logic [7:0]  b[40];
        logic [31:0] s;
        logic [63:0] d;
        int          nb;
        b = '{default: 8'h00};
        b[0] = 8'h45;
        {b[2], b[3]} = v.tot_len;
        {b[4], b[5]} = 16'h1234;
        b[6] = 8'h40;
        b[8] = 8'h40;
        b[9] = 8'h06;
        {b[12], b[13], b[14], b[15]} = SRC_IP;
        {b[16], b[17], b[18], b[19]} = v.dst_ip;
        {b[20], b[21]} = SRC_PORT;
        {b[22], b[23]} = v.dst_port;
        {b[24], b[25], b[26], b[27]} = SEQ_NUM;
        {b[28], b[29], b[30], b[31]} = ACK_NUM;
        b[32] = 8'h50;
        b[33] = v.flags;
        {b[34], b[35]} = 16'hffff;
        s = 0;
        for (int i = 0; i < 20; i += 2) s += {16'h0, b[i], b[i+1]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        {b[10], b[11]} = ~s[15:0];
        if (v.corrupt_byte >= 0) b[v.corrupt_byte] = b[v.corrupt_byte] ^ 8'h01;
        nb = (v.runt_beats > 0) ? v.runt_beats : 5 + v.n_pay;
        for (int k = 0; k < nb; k++) begin
            if (k < 5) begin
                d = '0;
                for (int n = 0; n < 8; n++) d = {b[8*k+n], d[63:8]};
            end else begin
                d = {16'hBEEF, 8'(id), 8'(k - 5), 32'h01234567 ^ 32'(k)};
                if (v.exp_pay > 0) exp_q.push_back(d);
            end
            tx_data_q.push_back(d);
            tx_keep_q.push_back((k == v.bad_keep_beat) ? 8'h7F : 8'hFF);
            tx_last_q.push_back(k == nb - 1);
        end
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        bit took;
        took = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        for (int n = 0; n < 200 && !took; n++) begin
            @(negedge aclk);
            took = s_tready;
            @(posedge aclk); #1;
        end
        if (!took) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no s_tready expected s_tready=1");
        end
    endtask

    task automatic send_pkt();
        while (tx_data_q.size() > 0)
            send_beat(tx_data_q.pop_front(), tx_keep_q.pop_front(), tx_last_q.pop_front());
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic apply_reset();
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic clear_mon();
        hdr_cnt = 0; acc_cnt = 0; stall_cnt = 0;
        mq.delete(); exp_q.delete();
    endtask

    task automatic check_payload(input string tag);
        check({tag, " pay_cnt"}, mq.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < mq.size(); k++) begin
            check($sformatf("%s pay%0d data", tag, k), mq[k][63:0], exp_q[k]);
            check($sformatf("%s pay%0d keep", tag, k), mq[k][71:64], 8'hFF);
            check($sformatf("%s pay%0d last", tag, k), mq[k][72], (k == exp_q.size() - 1));
        end
    endtask

    task automatic check_fields(input string tag, input logic [15:0] plen, input logic [7:0] flags);
        check({tag, " plen"},     cap_plen,     plen);
        check({tag, " flags"},    cap_flags,    flags);
        check({tag, " src_ip"},   cap_src_ip,   SRC_IP);
        check({tag, " src_port"}, cap_src_port, SRC_PORT);
        check({tag, " seq"},      cap_seq,      SEQ_NUM);
        check({tag, " ack"},      cap_ack,      ACK_NUM);
    endtask

    initial begin
        string tag;
        vec_t  v;
        toggle_mode = 0; prev_stall = 0; prev_data = '0;
        hdr_cnt = 0; acc_cnt = 0; stall_cnt = 0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
        aresetn = 1'b0;

        //        dst_ip    port        len     flags  pay runt corr keep hdr ok drop acc npay plen
        vecs[0]  = '{LOCAL_IP, LOCAL_PORT, 16'd56, 8'h02, 2, 0, -1, -1, 1, 1, 0, 7, 2, 16'd16};
        vecs[1]  = '{LOCAL_IP, 16'd1025,   16'd56, 8'h02, 2, 0, -1, -1, 0, 0, 1, 7, 0, 16'd0};
        vecs[2]  = '{32'hddccbbab, LOCAL_PORT, 16'd56, 8'h02, 2, 0, -1, -1, 0, 0, 1, 7, 0, 16'd0};
        vecs[3]  = '{LOCAL_IP, LOCAL_PORT, 16'd39, 8'h02, 2, 0, -1, -1, 0, 0, 1, 7, 0, 16'd0};
        vecs[4]  = '{LOCAL_IP, LOCAL_PORT, 16'd40, 8'h10, 0, 0, -1, -1, 1, 1, 0, 5, 0, 16'd0};
        vecs[5]  = '{LOCAL_IP, LOCAL_PORT, 16'd56, 8'h02, 2, 3, -1, -1, 0, 0, 1, 3, 0, 16'd0};
        vecs[6]  = '{LOCAL_IP, LOCAL_PORT, 16'd56, 8'h02, 2, 0,  0, -1, 0, 0, 1, 7, 0, 16'd0};
        vecs[7]  = '{LOCAL_IP, LOCAL_PORT, 16'd56, 8'h02, 2, 0,  9, -1, 0, 0, 1, 7, 0, 16'd0};
        vecs[8]  = '{LOCAL_IP, LOCAL_PORT, 16'd56, 8'h02, 2, 0, -1,  3, 0, 0, 1, 7, 0, 16'd0};
        vecs[9]  = '{LOCAL_IP, LOCAL_PORT, 16'd64, 8'h18, 3, 0, -1, -1, 1, 1, 0, 8, 3, 16'd24};
`ifdef IP_CSUM_CHECK_EN
        vecs[10] = '{LOCAL_IP, LOCAL_PORT, 16'd56, 8'h02, 2, 0, 11, -1, 0, 0, 1, 7, 0, 16'd0};
`else
        vecs[10] = '{LOCAL_IP, LOCAL_PORT, 16'd56, 8'h02, 2, 0, 11, -1, 1, 1, 0, 7, 2, 16'd16};
`endif

        // Reset state
        @(negedge aclk);
        check("rst s_tready",     s_tready,     1);
        check("rst m_tvalid",     m_tvalid,     0);
        check("rst m_tdata",      m_tdata,      0);
        check("rst hdr_valid",    hdr_valid,    0);
        check("rst hdr_src_ip",   hdr_src_ip,   0);
        check("rst pkt_ok_cnt",   pkt_ok_cnt,   0);
        check("rst pkt_drop_cnt", pkt_drop_cnt, 0);

        // Table of single-packet vectors, each from a fresh reset
        for (int i = 0; i < NV; i++) begin
            apply_reset();
            clear_mon();
            build_pkt(vecs[i], i);
            send_pkt();
            idle(6);
            tag = $sformatf("vec%0d", i);
            check({tag, " hdr_cnt"},  hdr_cnt,      vecs[i].exp_hdr);
            check({tag, " ok_cnt"},   pkt_ok_cnt,   vecs[i].exp_ok);
            check({tag, " drop_cnt"}, pkt_drop_cnt, vecs[i].exp_drop);
            check({tag, " acc_cnt"},  acc_cnt,      vecs[i].exp_acc);
            check_payload(tag);
            if (vecs[i].exp_hdr != 0) begin
                check_fields(tag, vecs[i].exp_plen, vecs[i].flags);
                check({tag, " plen_held"}, hdr_payload_len, vecs[i].exp_plen);
            end
        end

        // Runt followed back-to-back by a good packet, then a dropped one
        apply_reset();
        clear_mon();
        v = mkv(LOCAL_IP, LOCAL_PORT, 16'd56, 8'h02, 2, 0);
        v.runt_beats = 3;
        build_pkt(v, 20);
        build_pkt(mkv(LOCAL_IP, LOCAL_PORT, 16'd56, 8'h02, 2, 2), 21);
        send_pkt();
        idle(6);
        check("runt drop_cnt", pkt_drop_cnt, 1);
        check("runt ok_cnt",   pkt_ok_cnt,   1);
        check("runt hdr_cnt",  hdr_cnt,      1);
        check_fields("runt next", 16'd16, 8'h02);
        check_payload("runt next");
        clear_mon();
        build_pkt(mkv(LOCAL_IP, 16'd1025, 16'd64, 8'h18, 3, 0), 22);
        send_pkt();
        idle(6);
        check("hold hdr_cnt",   hdr_cnt,         0);
        check("hold drop_cnt",  pkt_drop_cnt,    2);
        check("hold plen",      hdr_payload_len, 16'd16);
        check("hold flags",     hdr_tcp_flags,   8'h02);

        // Header-only packet back-to-back with a 56-byte packet
        apply_reset();
        clear_mon();
        build_pkt(mkv(LOCAL_IP, LOCAL_PORT, 16'd40, 8'h10, 0, 0), 30);
        build_pkt(mkv(LOCAL_IP, LOCAL_PORT, 16'd56, 8'h02, 2, 2), 31);
        send_pkt();
        idle(6);
        check("b2b hdr_cnt",  hdr_cnt,      2);
        check("b2b ok_cnt",   pkt_ok_cnt,   2);
        check("b2b drop_cnt", pkt_drop_cnt, 0);
        check("b2b acc_cnt",  acc_cnt,      12);
        check_fields("b2b second", 16'd16, 8'h02);
        check_payload("b2b");

        // Payload back-pressure with m_tready toggling every cycle
        apply_reset();
        clear_mon();
        toggle_mode = 1;
        build_pkt(mkv(LOCAL_IP, LOCAL_PORT, 16'd72, 8'h02, 4, 4), 40);
        send_pkt();
        idle(10);
        toggle_mode = 0;
        idle(2);
        check("stall ok_cnt",   pkt_ok_cnt, 1);
        check("stall acc_cnt",  acc_cnt,    9);
        check("stall seen",     (stall_cnt > 0), 1);
        check_payload("stall");

        // Reset asserted mid-header; next packet must parse from beat 0
        apply_reset();
        clear_mon();
        build_pkt(mkv(LOCAL_IP, LOCAL_PORT, 16'd56, 8'h02, 2, 0), 50);
        for (int j = 0; j < 3; j++)
            send_beat(tx_data_q.pop_front(), tx_keep_q.pop_front(), tx_last_q.pop_front());
        aresetn = 1'b0; s_tvalid = 1'b0;
        tx_data_q.delete(); tx_keep_q.delete(); tx_last_q.delete();
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        clear_mon();
        build_pkt(mkv(LOCAL_IP, LOCAL_PORT, 16'd56, 8'h02, 2, 2), 51);
        send_pkt();
        idle(6);
        check("midrst ok_cnt",   pkt_ok_cnt,   1);
        check("midrst drop_cnt", pkt_drop_cnt, 0);
        check("midrst hdr_cnt",  hdr_cnt,      1);
        check_payload("midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ip_packet_parser.md
Name: ip_packet_parser

Overview:
- Receive-side counterpart of the IP/TCP packet generator.
- Consumes a 64-bit AXI-Stream carrying IPv4 (IHL=5) + TCP (no options) frames. Parses and filters the 40-byte header against local IP/port, and emits extracted header fields as a one-cycle record.
- Forwards TCP payload beats on an output AXI-Stream.
- Sits on the aclk domain between the SRIO/UDP receive path and the TCP control logic.

Parameters:
- CNT_W, 16, width of the accepted/dropped packet counters (saturating).
- HDR_BEATS, 5, header length in 64-bit beats; fixed at 5 (40 bytes).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- local_ip_addr  in  32  IP address accepted as destination
- local_port  in  16  TCP port accepted as destination
- s_tdata  in  64  input stream data; packet byte n of a beat is at [8n+7:8n]
- s_tkeep  in  8  input byte enables
- s_tvalid  in  1  input valid
- s_tlast  in  1  input end of packet
- s_tready  out  1  input ready
- m_tdata  out  64  payload data
- m_tkeep  out  8  payload byte enables
- m_tvalid  out  1  payload valid
- m_tlast  out  1  payload end of packet
- m_tready  in  1  payload ready
- hdr_valid  out  1  one-cycle pulse: header record valid
- hdr_src_ip  out  32  source IP
- hdr_src_port  out  16  TCP source port
- hdr_seq  out  32  TCP sequence number
- hdr_ack  out  32  TCP acknowledge number
- hdr_tcp_flags  out  8  TCP flags byte (byte 33)
- hdr_payload_len  out  16  IP total length minus 40
- pkt_ok_cnt  out  CNT_W  accepted packets
- pkt_drop_cnt  out  CNT_W  dropped packets

Behaviour:
- Multi-byte fields are big-endian in packet byte order.
- Header field locations (beat:bytes):
  - beat0 b0 = 0x45 required; b2-3 = total length
  - beat1 b9 = protocol, must be 6; b12-15 = source IP
  - beat2 b16-19 = destination IP; b20-21 = source port; b22-23 = destination port
  - beat3 = seq, ack
  - beat4 b33 = flags
- States:
  - HDR: beat_cnt 0..4
  - PAYLOAD
  - DROP
- Reset: state = HDR, beat_cnt = 0. All outputs 0 and both counters 0, except s_tready = 1.
- HDR state:
  - s_tready = 1.
  - Each accepted beat (s_tvalid & s_tready) latches its fields and increments beat_cnt.
  - Error flag is set if any of the following holds:
    - s_tkeep != 8'hFF
    - version/IHL byte != 0x45
    - protocol != 6
    - total length < 40
    - destination IP != local_ip_addr
    - destination port != local_port
  - Error flag clears at the start of each packet.
- s_tlast on header beat 0..3 (runt): pkt_drop_cnt++, beat_cnt = 0, stay in HDR, no hdr_valid.
- On acceptance of beat 4:
  - If error: pkt_drop_cnt++. If s_tlast, go to HDR; else go to DROP.
  - If no error: hdr_valid pulses the next cycle with the registered fields, and pkt_ok_cnt++.
    - s_tlast (header-only packet): go to HDR.
    - Otherwise: go to PAYLOAD.
- PAYLOAD state:
  - Combinational pass-through, zero latency: m_tdata/m_tkeep/m_tlast = s_*; m_tvalid = s_tvalid; s_tready = m_tready.
  - Accepted beat with tlast: go to HDR, beat_cnt = 0.
  - m_tvalid is held with stable data until m_tready is asserted (AXIS rules).
- DROP state:
  - s_tready = 1, m_tvalid = 0.
  - Beats are discarded until tlast, then go to HDR.
- Counters saturate at all-ones.
- hdr_* fields hold their values between pulses.
- local_ip_addr and local_port are sampled at beat 2 acceptance.
- hdr_payload_len is 16-bit unsigned subtraction, computed only when total length >= 40.
- Back-to-back packets with no idle cycle are supported. The beat after tlast is beat 0 of the next packet.
- An aresetn assertion mid-packet aborts immediately. The partial packet is not counted. After release, the first beat seen is treated as header beat 0.

Optional Feature:
- Macro: IP_CSUM_CHECK_EN.
- When defined:
  - A ones'-complement sum of the 10 IP header halfwords (beats 0-1 plus beat 2 bytes 16-19) is accumulated in a 17-bit end-around-carry register.
  - A final sum != 16'hFFFF sets the error flag, so the packet is dropped and counted.
- When undefined: no checksum logic is built, and checksum bytes are ignored.

Decomposition:
- Package ip_pkt_pkg holds:
  - constants IP_VER_IHL = 8'h45, PROTO_TCP = 8'd6, HDR_BYTES = 40
  - state enum {HDR, PAYLOAD, DROP}
  - byte-offset localparams for each field
- One sub-module: ip_csum_acc (ones'-complement halfword accumulator with clear/add/result), instantiated only under IP_CSUM_CHECK_EN.

Test Plan:
- Matching packet, local 0xddccbbaa:1024, total length 56, flags 0x02, 2 payload beats, m_tready = 1:
  - hdr_valid pulses once, hdr_payload_len = 16, hdr_tcp_flags = 0x02.
  - 2 payload beats appear unchanged, m_tlast on beat 2, pkt_ok_cnt = 1.
- Destination port 1025, otherwise identical: no hdr_valid, no m_tvalid, pkt_drop_cnt = 1, all 7 beats accepted.
- Runt: tlast on beat 2: pkt_drop_cnt = 1; next valid packet is parsed correctly.
- Header-only packet (total length 40, tlast on beat 4) followed back-to-back by a 56-byte packet: two hdr_valid pulses, pkt_ok_cnt = 2.
- m_tready toggled 1010 during payload: s_tready mirrors m_tready, no beat is lost or duplicated, data stays stable while stalled.
- With IP_CSUM_CHECK_EN, header checksum byte corrupted by flipping bit 0: packet dropped, pkt_drop_cnt = 1. With the correct checksum, the packet is accepted.
